// File: rtl/npu_core_sched_if.sv
// Operand handshake, NPU core control pins and reconstructed output-valid
// shared between the scheduler (master) and the core/feature buffer (slave).
interface npu_core_sched_if #(
  parameter int NPU_OUT_NUM   = 18,
  parameter int PIX_CNT_WIDTH = 16
);
  logic                     src_valid;
  logic                     src_ready;
  logic                     npu_bias_sel;
  logic                     npu_zero_op;
  logic                     npu_data_valid;
  logic [NPU_OUT_NUM-1:0]   adder_rst;
  logic [3:0]               npu_scale;
  logic                     out_valid;
  logic [PIX_CNT_WIDTH-1:0] out_pix_idx;

  modport master (
    input  src_valid,
    output src_ready, npu_bias_sel, npu_zero_op, npu_data_valid,
           adder_rst, npu_scale, out_valid, out_pix_idx
  );

  modport slave (
    output src_valid,
    input  src_ready, npu_bias_sel, npu_zero_op, npu_data_valid,
           adder_rst, npu_scale, out_valid, out_pix_idx
  );
endinterface

// File: rtl/npu_core_sched.sv
// Layer-job sequencer for one NPU core: paces operand beats, drives the core
// control pins and rebuilds the core's output-valid from per-beat delay lines.
module npu_core_sched #(
  parameter int ACC_CNT_WIDTH = 8,
  parameter int PIX_CNT_WIDTH = 16,
  parameter int NPU_OUT_NUM   = 18,
  parameter int APM_LAT       = 11,
  parameter int POST_LAT      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [ACC_CNT_WIDTH-1:0] cfg_acc_len,
  input  logic [PIX_CNT_WIDTH-1:0] cfg_pix_num,
  input  logic [3:0]               cfg_scale,
  input  logic                     abort,
  npu_core_sched_if.master         bus,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);
  localparam int unsigned LB_LEN = APM_LAT + POST_LAT;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [ACC_CNT_WIDTH-1:0] acc_len_q, beat_cnt_q;
  logic [PIX_CNT_WIDTH-1:0] pix_num_q, pix_cnt_q;
  logic [3:0]               scale_q;
  logic                     cfg_err_q;
  logic [APM_LAT-1:0]       fb_dl;
  logic [LB_LEN-1:0]        lb_dl;
  logic [PIX_CNT_WIDTH-1:0] idx_dl [LB_LEN];

  logic accept, beat_first, beat_last, pix_last, cfg_ok, start_ok, kill, final_out;

  assign cfg_ok     = (cfg_acc_len != '0) && (cfg_pix_num != '0);
  assign start_ok   = (state_q == S_IDLE) && cfg_start && cfg_ok;
  assign kill       = abort && (state_q != S_IDLE);
  assign accept     = bus.src_valid && (state_q == S_RUN);
  assign beat_first = (beat_cnt_q == '0);
  assign beat_last  = (beat_cnt_q == acc_len_q - ACC_CNT_WIDTH'(1));
  assign pix_last   = (pix_cnt_q == pix_num_q - PIX_CNT_WIDTH'(1));
  // Pixel indices are unique within a job, so the tail of the last-beat line
  // carrying the final index in DRAIN is the job's last output.
  assign final_out  = (state_q == S_DRAIN) && lb_dl[LB_LEN-1] &&
                      (idx_dl[LB_LEN-1] == pix_num_q - PIX_CNT_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.src_ready   = 1'b0;
    bus.npu_zero_op = 1'b1;
    busy            = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_RUN;
      end
      S_RUN: begin
        bus.src_ready   = 1'b1;
        bus.npu_zero_op = !bus.src_valid;
        busy            = 1'b1;
        if (abort)                                state_d = S_IDLE;
        else if (accept && beat_last && pix_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (abort || final_out) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.npu_data_valid = accept;
  assign bus.npu_bias_sel   = accept && beat_first;
  assign bus.adder_rst      = {NPU_OUT_NUM{fb_dl[APM_LAT-1]}};
  assign bus.npu_scale      = scale_q;
  assign bus.out_valid      = lb_dl[LB_LEN-1];
  assign bus.out_pix_idx    = idx_dl[LB_LEN-1];
  assign done               = final_out;
  assign cfg_err            = cfg_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_len_q  <= '0;
      beat_cnt_q <= '0;
      pix_num_q  <= '0;
      pix_cnt_q  <= '0;
      scale_q    <= '0;
      cfg_err_q  <= 1'b0;
      fb_dl      <= '0;
      lb_dl      <= '0;
      for (int unsigned i = 0; i < LB_LEN; i++) idx_dl[i] <= '0;
    end else begin
      cfg_err_q <= (state_q == S_IDLE) && cfg_start && !cfg_ok;
      if (kill) begin
        beat_cnt_q <= '0;
        pix_cnt_q  <= '0;
        fb_dl      <= '0;
        lb_dl      <= '0;
        for (int unsigned i = 0; i < LB_LEN; i++) idx_dl[i] <= '0;
      end else begin
        fb_dl     <= {fb_dl[APM_LAT-2:0], accept && beat_first};
        lb_dl     <= {lb_dl[LB_LEN-2:0], accept && beat_last};
        idx_dl[0] <= pix_cnt_q;
        for (int unsigned i = 1; i < LB_LEN; i++) idx_dl[i] <= idx_dl[i-1];
        if (accept) begin
          if (beat_last) begin
            beat_cnt_q <= '0;
            pix_cnt_q  <= pix_cnt_q + PIX_CNT_WIDTH'(1);
          end else begin
            beat_cnt_q <= beat_cnt_q + ACC_CNT_WIDTH'(1);
          end
        end
      end
      if (start_ok) begin
        acc_len_q  <= cfg_acc_len;
        pix_num_q  <= cfg_pix_num;
        scale_q    <= cfg_scale;
        beat_cnt_q <= '0;
        pix_cnt_q  <= '0;
      end
    end
  end
endmodule
